// File: rtl/em_pipe_reg.sv
// E/M pipeline register: captures E-stage results and control fields for the M stage,
// merges ALU overflow into the exception code, and supports stall-hold and flush-to-bubble.
module em_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] FLUSH_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_OV   = 5'd12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        E_valid,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_instr,
  input  logic [31:0] E_ALUresult,
  input  logic [31:0] E_rtdata,
  input  logic        E_calcROV,
  input  logic        E_DMOV,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  input  logic [4:0]  E_regWA,
  input  logic [1:0]  E_Tnew,
  output logic        M_valid,
  output logic [31:0] M_PC,
  output logic [31:0] M_instr,
  output logic [31:0] M_ALUresult,
  output logic [31:0] M_rtdata,
  output logic        M_DMOV,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD,
  output logic [4:0]  M_regWA,
  output logic [1:0]  M_Tnew
);

  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] alu_reg;
  logic [31:0] rtdata_reg;
  logic        dmov_reg;
  logic [4:0]  exc_reg;
  logic        bd_reg;
  logic [4:0]  regwa_reg;
  logic [1:0]  tnew_reg;

  logic [4:0]  exc_next;
  logic        dmov_next;
  logic [4:0]  regwa_next;
  logic [1:0]  tnew_next;

  // Values captured on a normal load; an invalid E slot carries no write or exception.
  always_comb begin
    exc_next   = 5'd0;
    dmov_next  = 1'b0;
    regwa_next = 5'd0;
    tnew_next  = (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
    if (E_valid) begin
      dmov_next  = E_DMOV;
      regwa_next = E_regWA;
      if (E_ExcCode != 5'd0)
        exc_next = E_ExcCode;
      else if (E_calcROV)
        exc_next = EXC_OV;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_reg  <= 1'b0;
      pc_reg     <= reset ? RESET_PC : FLUSH_PC;
      instr_reg  <= 32'd0;
      alu_reg    <= 32'd0;
      rtdata_reg <= 32'd0;
      dmov_reg   <= 1'b0;
      exc_reg    <= 5'd0;
      bd_reg     <= 1'b0;
      regwa_reg  <= 5'd0;
      tnew_reg   <= 2'd0;
    end else if (!stall) begin
      valid_reg  <= E_valid;
      pc_reg     <= E_PC;
      instr_reg  <= E_instr;
      alu_reg    <= E_ALUresult;
      rtdata_reg <= E_rtdata;
      dmov_reg   <= dmov_next;
      exc_reg    <= exc_next;
      bd_reg     <= E_BD;
      regwa_reg  <= regwa_next;
      tnew_reg   <= tnew_next;
    end
  end

  assign M_valid     = valid_reg;
  assign M_PC        = pc_reg;
  assign M_instr     = instr_reg;
  assign M_ALUresult = alu_reg;
  assign M_rtdata    = rtdata_reg;
  assign M_DMOV      = dmov_reg;
  assign M_ExcCode   = exc_reg;
  assign M_BD        = bd_reg;
  assign M_regWA     = regwa_reg;
  assign M_Tnew      = tnew_reg;

endmodule

// File: tb/tb_em_pipe_reg.sv
// Bench for em_pipe_reg: directed vector table followed by randomized traffic
// checked against a behavioural model of the stage register.
module tb_em_pipe_reg;

  typedef struct packed {
    logic        reset, flush, stall, valid;
    logic [31:0] pc, instr, alu, rt;
    logic        rov, dmov;
    logic [4:0]  exc;
    logic        bd;
    logic [4:0]  wa;
    logic [1:0]  tnew;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, instr, alu, rt;
    logic        dmov;
    logic [4:0]  exc;
    logic        bd;
    logic [4:0]  wa;
    logic [1:0]  tnew;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush, stall, E_valid, E_calcROV, E_DMOV, E_BD;
  logic [31:0] E_PC, E_instr, E_ALUresult, E_rtdata;
  logic [4:0]  E_ExcCode, E_regWA;
  logic [1:0]  E_Tnew;
  logic        M_valid, M_DMOV, M_BD;
  logic [31:0] M_PC, M_instr, M_ALUresult, M_rtdata;
  logic [4:0]  M_ExcCode, M_regWA;
  logic [1:0]  M_Tnew;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  em_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .E_valid(E_valid), .E_PC(E_PC), .E_instr(E_instr), .E_ALUresult(E_ALUresult),
    .E_rtdata(E_rtdata), .E_calcROV(E_calcROV), .E_DMOV(E_DMOV), .E_ExcCode(E_ExcCode),
    .E_BD(E_BD), .E_regWA(E_regWA), .E_Tnew(E_Tnew),
    .M_valid(M_valid), .M_PC(M_PC), .M_instr(M_instr), .M_ALUresult(M_ALUresult),
    .M_rtdata(M_rtdata), .M_DMOV(M_DMOV), .M_ExcCode(M_ExcCode), .M_BD(M_BD),
    .M_regWA(M_regWA), .M_Tnew(M_Tnew)
  );

  // Instruction and store data are derived from PC and ALU result to keep the table compact.
  function automatic in_t mk_in(logic rs, logic fl, logic st, logic v, logic [31:0] pc,
                                logic [31:0] alu, logic rov, logic dmov, logic [4:0] exc,
                                logic bd, logic [4:0] wa, logic [1:0] tnew);
    in_t i;
    i.reset = rs; i.flush = fl; i.stall = st; i.valid = v;
    i.pc = pc; i.instr = pc ^ 32'hA5A5_0000; i.alu = alu; i.rt = ~alu;
    i.rov = rov; i.dmov = dmov; i.exc = exc; i.bd = bd; i.wa = wa; i.tnew = tnew;
    return i;
  endfunction

  function automatic out_t mk_out(logic v, logic [31:0] pc, logic [31:0] alu, logic dmov,
                                  logic [4:0] exc, logic bd, logic [4:0] wa,
                                  logic [1:0] tnew, logic bubble);
    out_t o;
    o.valid = v; o.pc = pc; o.alu = alu; o.dmov = dmov; o.exc = exc;
    o.bd = bd; o.wa = wa; o.tnew = tnew;
    o.instr = bubble ? 32'd0 : (pc ^ 32'hA5A5_0000);
    o.rt    = bubble ? 32'd0 : ~alu;
    return o;
  endfunction

  // Reference model: what M should hold after one clock edge given the previous contents.
  function automatic out_t model(out_t prev, in_t i);
    out_t n;
    if (i.reset) begin
      n = '0; n.pc = 32'h0000_3000;
    end else if (i.flush) begin
      n = '0; n.pc = 32'h0000_4180;
    end else if (i.stall) begin
      n = prev;
    end else begin
      n.valid = i.valid; n.pc = i.pc; n.instr = i.instr; n.alu = i.alu;
      n.rt = i.rt; n.bd = i.bd;
      n.tnew = (i.tnew > 0) ? i.tnew - 2'd1 : 2'd0;
      if (!i.valid) begin
        n.exc = 5'd0; n.dmov = 1'b0; n.wa = 5'd0;
      end else begin
        n.dmov = i.dmov; n.wa = i.wa;
        if (i.exc != 0)  n.exc = i.exc;
        else if (i.rov)  n.exc = 5'd12;
        else             n.exc = 5'd0;
      end
    end
    return n;
  endfunction

  function automatic out_t read_dut();
    return {M_valid, M_PC, M_instr, M_ALUresult, M_rtdata, M_DMOV, M_ExcCode,
            M_BD, M_regWA, M_Tnew};
  endfunction

  task automatic drive(in_t i);
    reset = i.reset; flush = i.flush; stall = i.stall; E_valid = i.valid;
    E_PC = i.pc; E_instr = i.instr; E_ALUresult = i.alu; E_rtdata = i.rt;
    E_calcROV = i.rov; E_DMOV = i.dmov; E_ExcCode = i.exc; E_BD = i.bd;
    E_regWA = i.wa; E_Tnew = i.tnew;
  endtask

  task automatic check(string name, out_t act, out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got v=%0b pc=%h alu=%h ins=%h rt=%h dmov=%0b exc=%0d bd=%0b wa=%0d tnew=%0d; want v=%0b pc=%h alu=%h ins=%h rt=%h dmov=%0b exc=%0d bd=%0b wa=%0d tnew=%0d",
               name, act.valid, act.pc, act.alu, act.instr, act.rt, act.dmov, act.exc, act.bd,
               act.wa, act.tnew, exp.valid, exp.pc, exp.alu, exp.instr, exp.rt, exp.dmov,
               exp.exc, exp.bd, exp.wa, exp.tnew);
    end
  endtask

  out_t state;
  logic have_state = 1'b0;

  // One transaction: drive, confirm outputs do not react before the edge, then check after it.
  task automatic step(string name, in_t i, out_t exp);
    drive(i);
    #2;
    if (have_state) check({name, "_nocomb"}, read_dut(), state);
    @(posedge clk);
    #1;
    check(name, read_dut(), exp);
    state = model(state, i);
    have_state = 1'b1;
    $display("[TB] %s pc=%h exc=%0d wa=%0d tnew=%0d", name, M_PC, M_ExcCode, M_regWA, M_Tnew);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{mk_in(1,0,0,1,32'h3010,32'hDEAD_BEEF,1,1,5'd3,1,5'd9,2'd3),
                 mk_out(0,32'h3000,32'h0,0,5'd0,0,5'd0,2'd0,1)};
    vecs[1]  = '{mk_in(0,0,0,1,32'h3004,32'h1234_5678,0,0,5'd0,0,5'd3,2'd2),
                 mk_out(1,32'h3004,32'h1234_5678,0,5'd0,0,5'd3,2'd1,0)};
    vecs[2]  = '{mk_in(0,0,0,1,32'h3008,32'hAAAA_0000,1,0,5'd0,0,5'd4,2'd1),
                 mk_out(1,32'h3008,32'hAAAA_0000,0,5'd12,0,5'd4,2'd0,0)};
    vecs[3]  = '{mk_in(0,0,0,1,32'h3008,32'hAAAA_0004,1,0,5'd10,0,5'd4,2'd1),
                 mk_out(1,32'h3008,32'hAAAA_0004,0,5'd10,0,5'd4,2'd0,0)};
    vecs[4]  = '{mk_in(0,0,0,1,32'h3008,32'h0000_0100,0,1,5'd0,0,5'd7,2'd3),
                 mk_out(1,32'h3008,32'h0000_0100,1,5'd0,0,5'd7,2'd2,0)};
    vecs[5]  = '{mk_in(0,0,1,1,32'h3100,32'h1111_1111,1,0,5'd0,1,5'd1,2'd1),
                 mk_out(1,32'h3008,32'h0000_0100,1,5'd0,0,5'd7,2'd2,0)};
    vecs[6]  = '{mk_in(0,0,1,0,32'h3104,32'h2222_2222,0,0,5'd6,0,5'd2,2'd0),
                 mk_out(1,32'h3008,32'h0000_0100,1,5'd0,0,5'd7,2'd2,0)};
    vecs[7]  = '{mk_in(0,0,1,1,32'h3108,32'h3333_3333,1,1,5'd10,1,5'd3,2'd2),
                 mk_out(1,32'h3008,32'h0000_0100,1,5'd0,0,5'd7,2'd2,0)};
    vecs[8]  = '{mk_in(0,1,1,1,32'h3200,32'h4444_4444,1,1,5'd10,1,5'd6,2'd2),
                 mk_out(0,32'h4180,32'h0,0,5'd0,0,5'd0,2'd0,1)};
    vecs[9]  = '{mk_in(0,0,0,0,32'h3104,32'h0000_0055,1,1,5'd4,1,5'd5,2'd2),
                 mk_out(0,32'h3104,32'h0000_0055,0,5'd0,1,5'd0,2'd1,0)};
    vecs[10] = '{mk_in(0,0,0,1,32'h3108,32'h0000_0066,0,0,5'd0,0,5'd2,2'd0),
                 mk_out(1,32'h3108,32'h0000_0066,0,5'd0,0,5'd2,2'd0,0)};
    vecs[11] = '{mk_in(0,0,0,1,32'h300C,32'h0000_0077,1,0,5'd0,1,5'd8,2'd1),
                 mk_out(1,32'h300C,32'h0000_0077,0,5'd12,1,5'd8,2'd0,0)};
    vecs[12] = '{mk_in(1,0,1,1,32'h3110,32'h0000_0088,1,1,5'd3,1,5'd8,2'd3),
                 mk_out(0,32'h3000,32'h0,0,5'd0,0,5'd0,2'd0,1)};
    vecs[13] = '{mk_in(0,1,0,1,32'h3114,32'h0000_0099,1,1,5'd3,1,5'd8,2'd3),
                 mk_out(0,32'h4180,32'h0,0,5'd0,0,5'd0,2'd0,1)};

    state = '0;
    for (int k = 0; k < 14; k++)
      step($sformatf("vec%0d", k), vecs[k].in, vecs[k].exp);

    for (int k = 0; k < 300; k++) begin
      in_t r;
      r.reset = ($urandom_range(0, 31) == 0);
      r.flush = ($urandom_range(0, 7) == 0);
      r.stall = ($urandom_range(0, 3) == 0);
      r.valid = ($urandom_range(0, 3) != 0);
      r.pc    = $urandom; r.instr = $urandom; r.alu = $urandom; r.rt = $urandom;
      r.rov   = 1'($urandom_range(0, 1));
      r.dmov  = 1'($urandom_range(0, 1));
      r.exc   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.bd    = 1'($urandom_range(0, 1));
      r.wa    = 5'($urandom_range(0, 31));
      r.tnew  = 2'($urandom_range(0, 3));
      step($sformatf("rnd%0d", k), r, model(state, r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
